// File: rtl/math_pkg.sv
// Shared constants and sizing helpers for the fixed-point math library.
package math_pkg;

  localparam int MATH_DIGIT_W = 17;

  function automatic int math_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Lets a parent size the delay lines that run alongside a math_mult_wide.
  function automatic int math_mult_lat(input int wb);
    return math_ceil_div(wb, MATH_DIGIT_W) + 2;
  endfunction

endpackage

// File: rtl/math_mult_wide_stage.sv
// One registered multiply-accumulate step: acc += a * digit << SHIFT.
// Also delays operand A, the full B word, the mode bit and the valid bit.
module math_mult_wide_stage
  import math_pkg::*;
#(
  parameter int WIDTH_A      = 42,
  parameter int WIDTH_BX     = 51,
  parameter int WIDTH_ACC    = 78,
  parameter int SHIFT        = 0,
  parameter bit DIGIT_SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    valid_in,
  input  logic                    mode_in,
  input  logic [WIDTH_A:0]        a_in,
  input  logic [WIDTH_BX-1:0]     b_in,
  input  logic [MATH_DIGIT_W-1:0] digit,
  input  logic [WIDTH_ACC-1:0]    acc_in,
  output logic                    valid_out,
  output logic                    mode_out,
  output logic [WIDTH_A:0]        a_out,
  output logic [WIDTH_BX-1:0]     b_out,
  output logic [WIDTH_ACC-1:0]    acc_out
);

  localparam int PROD_W = WIDTH_A + 1 + MATH_DIGIT_W + 1;

  logic signed [MATH_DIGIT_W:0] digit_ext;
  logic signed [PROD_W-1:0]     prod;
  logic signed [WIDTH_ACC-1:0]  term;

  // Only the most significant digit carries a sign, and only in signed mode.
  always_comb begin
    digit_ext = {(DIGIT_SIGNED && mode_in) ? digit[MATH_DIGIT_W-1] : 1'b0, digit};
    prod      = $signed(a_in) * digit_ext;
    term      = WIDTH_ACC'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      mode_out  <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      acc_out   <= '0;
    end else if (ena) begin
      valid_out <= valid_in;
      mode_out  <= mode_in;
      a_out     <= a_in;
      b_out     <= b_in;
      acc_out   <= acc_in + WIDTH_ACC'(term << SHIFT);
    end
  end

endmodule

// File: rtl/math_mult_wide.sv
// Fully pipelined wide multiplier: input register, one MAC stage per 17-bit
// digit of B, output register. Per-transaction signed/unsigned mode.
module math_mult_wide
  import math_pkg::*;
#(
  parameter int WIDTH_A = 42,
  parameter int WIDTH_B = 35
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       din_valid,
  input  logic                       din_signed,
  input  logic [WIDTH_A-1:0]         dina,
  input  logic [WIDTH_B-1:0]         dinb,
  output logic                       dout_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] dout
);

  localparam int NB        = math_ceil_div(WIDTH_B, MATH_DIGIT_W);
  localparam int WIDTH_P   = WIDTH_A + WIDTH_B;
  localparam int WIDTH_BX  = NB * MATH_DIGIT_W;
  localparam int WIDTH_ACC = WIDTH_P + 1;

  logic               a_r_signed;
  logic               v_r;
  logic [WIDTH_A-1:0] a_r;
  logic [WIDTH_B-1:0] b_r;

  logic                 v_p [NB+1];
  logic                 s_p [NB+1];
  logic [WIDTH_A:0]     a_p [NB+1];
  logic [WIDTH_BX-1:0]  b_p [NB+1];
  logic [WIDTH_ACC-1:0] acc [NB+1];
  logic                 tail_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r        <= 1'b0;
      a_r_signed <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
    end else if (ena) begin
      v_r        <= din_valid;
      a_r_signed <= din_signed;
      a_r        <= dina;
      b_r        <= dinb;
    end
  end

  // Extension happens after the input register so the stage-0 flops stay narrow.
  assign v_p[0] = v_r;
  assign s_p[0] = a_r_signed;
  assign a_p[0] = a_r_signed ? (WIDTH_A+1)'($signed(a_r)) : (WIDTH_A+1)'(a_r);
  assign b_p[0] = a_r_signed ? WIDTH_BX'($signed(b_r))    : WIDTH_BX'(b_r);
  assign acc[0] = '0;

  for (genvar k = 0; k < NB; k++) begin : g_stage
    math_mult_wide_stage #(
      .WIDTH_A      (WIDTH_A),
      .WIDTH_BX     (WIDTH_BX),
      .WIDTH_ACC    (WIDTH_ACC),
      .SHIFT        (MATH_DIGIT_W * k),
      .DIGIT_SIGNED (k == NB - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .valid_in  (v_p[k]),
      .mode_in   (s_p[k]),
      .a_in      (a_p[k]),
      .b_in      (b_p[k]),
      .digit     (b_p[k][MATH_DIGIT_W*k +: MATH_DIGIT_W]),
      .acc_in    (acc[k]),
      .valid_out (v_p[k+1]),
      .mode_out  (s_p[k+1]),
      .a_out     (a_p[k+1]),
      .b_out     (b_p[k+1]),
      .acc_out   (acc[k+1])
    );
  end

  // The accumulator guard bit and the last stage's pass-through operands are not needed.
  assign tail_unused = ^{acc[NB][WIDTH_P], a_p[NB], b_p[NB], s_p[NB]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (ena) begin
      dout_valid <= v_p[NB];
      dout       <= acc[NB][WIDTH_P-1:0];
    end
  end

endmodule
